// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the bridge address window and the responder FSM states.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] AHB_BASE  = 32'h8000_0000;
    localparam logic [31:0] AHB_LIMIT = 32'h8BFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic htrans_active(input logic [1:0] trans);
        logic act;
        case (trans)
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    function automatic logic in_window(input logic [31:0] addr);
        return (addr >= AHB_BASE) && (addr <= AHB_LIMIT);
    endfunction

endpackage

// File: rtl/ahb_resp_regfile.sv
// Word register file for the AHB responder: synchronous write, combinational read,
// asynchronous clear.
module ahb_resp_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             Hclk,
    input  logic             Hreset,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB-Lite responder: window decode, configurable wait states, two-cycle ERROR,
// and a small word register file behind the data phase.
module ahb_slave_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH       = 16
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    import ahb_pkg::*;

    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [2:0]  WaitLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e            state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic              wr_q, wr_d;
    logic              inwin_q, inwin_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              accept;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    assign Hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign Hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign accept    = htrans_active(Htrans) && Hreadyin && Hreadyout;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wr_d    = wr_q;
        inwin_d = inwin_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    wr_d    = Hwrite;
                    idx_d   = Haddr[IdxW+1:2];
                    inwin_d = in_window(Haddr);
                    if (!in_window(Haddr)) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WaitLoad;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            wr_q    <= 1'b0;
            inwin_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wr_q    <= wr_d;
            inwin_q <= inwin_d;
            idx_q   <= idx_d;
        end
    end

    // Write commits at the edge closing the data phase, so a pipelined read sees it.
    assign mem_we = (state_q == ST_DATA) && wr_q && inwin_q;
    assign Hrdata = ((state_q == ST_DATA) && !wr_q) ? mem_rdata : 32'h0;

    ahb_resp_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_regfile (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .we     (mem_we),
        .addr   (idx_q),
        .wdata  (Hwdata),
        .rdata  (mem_rdata)
    );

endmodule
